// File: rtl/client_grant_arb_pkg.sv
// Shared types and constants for the memory arbiter slice: control register,
// FSM encodings, arbitration modes and small index helpers.
package client_grant_arb_pkg;

  localparam int MEM_ARB_CLIENTS_P = 3;
  localparam int CLIENTS_BWIDTH_P  = $clog2(MEM_ARB_CLIENTS_P);

  localparam logic [1:0] ARB_MODE_STATIC = 2'd0;
  localparam logic [1:0] ARB_MODE_DYN    = 2'd1;
  localparam logic [1:0] ARB_MODE_RR     = 2'd2;

  typedef struct packed {
    logic [1:0] mode;
  } ctrl_reg_t;

  typedef enum logic [1:0] {
    SORT_IDLE,
    SORT_RUN,
    SORT_DONE
  } sorter_states_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RSP
  } arb_states_t;

  function automatic logic [MEM_ARB_CLIENTS_P-1:0] id_to_onehot(
    input logic [CLIENTS_BWIDTH_P-1:0] id
  );
    id_to_onehot     = '0;
    id_to_onehot[id] = 1'b1;
  endfunction

  function automatic logic [CLIENTS_BWIDTH_P-1:0] next_rr(
    input logic [CLIENTS_BWIDTH_P-1:0] id
  );
    if (id == CLIENTS_BWIDTH_P'(MEM_ARB_CLIENTS_P - 1))
      next_rr = '0;
    else
      next_rr = id + CLIENTS_BWIDTH_P'(1);
  endfunction

endpackage

// File: rtl/client_grant_arb_prio_pick.sv
// Combinational winner selection: ordered priority list (with lowest-index
// fallback) or round-robin search starting at rr_ptr.
module prio_pick
  import client_grant_arb_pkg::*;
(
  input  logic [MEM_ARB_CLIENTS_P-1:0]                       req,
  input  logic [MEM_ARB_CLIENTS_P-1:0][CLIENTS_BWIDTH_P-1:0] cand,
  input  logic [CLIENTS_BWIDTH_P-1:0]                        rr_ptr,
  input  logic [1:0]                                         mode,
  output logic [CLIENTS_BWIDTH_P-1:0]                        winner,
  output logic                                               found
);

  logic [MEM_ARB_CLIENTS_P-1:0] seen;
  int                           rr_idx;

  always_comb begin
    // NOTE: every output and temporary gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    winner = '0;
    found  = 1'b0;
    seen   = '0;
    rr_idx = 0;

    if (mode == ARB_MODE_RR) begin
      for (int off = 0; off < MEM_ARB_CLIENTS_P; off++) begin
        rr_idx = (int'(rr_ptr) + off) % MEM_ARB_CLIENTS_P;
        if (!found && req[rr_idx]) begin
          winner = CLIENTS_BWIDTH_P'(rr_idx);
          found  = 1'b1;
        end
      end
    end else begin
      // Out-of-range and repeated list entries are skipped.
      for (int i = 0; i < MEM_ARB_CLIENTS_P; i++) begin
        if (int'(cand[i]) < MEM_ARB_CLIENTS_P && !seen[cand[i]]) begin
          seen[cand[i]] = 1'b1;
          if (!found && req[cand[i]]) begin
            winner = cand[i];
            found  = 1'b1;
          end
        end
      end
    end

    for (int i = 0; i < MEM_ARB_CLIENTS_P; i++) begin
      if (!found && req[i]) begin
        winner = CLIENTS_BWIDTH_P'(i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/client_grant_arb.sv
// Grants one client at a time and runs the memory valid/ready + response
// handshake for it; the grant is held until the response returns.
module client_grant_arb
  import client_grant_arb_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  ctrl_reg_t                     ctrl,
  input  logic [CLIENTS_BWIDTH_P-1:0]   prio_list0,
  input  logic [CLIENTS_BWIDTH_P-1:0]   prio_list1,
  input  logic [CLIENTS_BWIDTH_P-1:0]   prio_list2,
  input  logic [MEM_ARB_CLIENTS_P-1:0]  client_req,
  output logic [MEM_ARB_CLIENTS_P-1:0]  client_gnt,
  output logic [CLIENTS_BWIDTH_P-1:0]   gnt_id,
  output logic                          mem_valid,
  input  logic                          mem_ready,
  input  logic                          mem_rsp_valid,
  output logic [MEM_ARB_CLIENTS_P-1:0]  client_done,
  output logic                          busy
);

  arb_states_t                   state;
  logic [CLIENTS_BWIDTH_P-1:0]   rr_ptr;
  logic [CLIENTS_BWIDTH_P-1:0]   winner;
  logic                          found;

  prio_pick u_pick (
    .req    (client_req),
    .cand   ({prio_list2, prio_list1, prio_list0}),
    .rr_ptr (rr_ptr),
    .mode   (ctrl.mode),
    .winner (winner),
    .found  (found)
  );

  // The pick only matters in ARB_IDLE, so lists and mode are effectively
  // sampled there and ignored for the rest of a transaction.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    if (rst) begin
      state       <= ARB_IDLE;
      client_gnt  <= '0;
      gnt_id      <= '0;
      mem_valid   <= 1'b0;
      client_done <= '0;
      rr_ptr      <= '0;
    end else begin
      client_done <= '0;
      case (state)
        ARB_IDLE: begin
          if (found) begin
            client_gnt <= id_to_onehot(winner);
            gnt_id     <= winner;
            mem_valid  <= 1'b1;
            state      <= ARB_REQ;
            if (ctrl.mode == ARB_MODE_RR)
              rr_ptr <= next_rr(winner);
          end
        end
        ARB_REQ: begin
          if (mem_valid && mem_ready) begin
            mem_valid <= 1'b0;
            state     <= ARB_RSP;
          end
        end
        ARB_RSP: begin
          if (mem_rsp_valid) begin
            client_done <= client_gnt;
            client_gnt  <= '0;
            state       <= ARB_IDLE;
          end
        end
        default: begin
          client_gnt <= '0;
          mem_valid  <= 1'b0;
          state      <= ARB_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != ARB_IDLE);

endmodule

// File: doc/client_grant_arb.md
Name: client_grant_arb

Overview:
Consumer end of the priority-list interface. Takes the per-client request lines and the three priority-list entries (prio_list0..2) driven by the priority selector. Issues a single one-hot grant and runs the memory-side valid/ready plus response handshake for the granted client. The grant is held for the full transaction (request accepted, then response returned) before re-arbitration.

Parameters:
MEM_ARB_CLIENTS_P, 3, number of client interfaces; RTL is fixed at 3 priority-list inputs.
CLIENTS_BWIDTH_P, $clog2(MEM_ARB_CLIENTS_P), client index width (localparam).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ctrl  in  ctrl_reg_t  control register; ctrl.mode: 0 static, 1 dynamic (both use prio lists), 2 round-robin, 3 treated as 0
prio_list0  in  CLIENTS_BWIDTH_P  client index with highest priority
prio_list1  in  CLIENTS_BWIDTH_P  second priority
prio_list2  in  CLIENTS_BWIDTH_P  lowest priority
client_req  in  MEM_ARB_CLIENTS_P  per-client request; held high until client_done
client_gnt  out  MEM_ARB_CLIENTS_P  one-hot grant, registered
gnt_id  out  CLIENTS_BWIDTH_P  index of granted client, registered
mem_valid  out  1  request valid toward memory
mem_ready  in  1  memory accepts request
mem_rsp_valid  in  1  memory response for the outstanding request
client_done  out  MEM_ARB_CLIENTS_P  one-cycle one-hot pulse on response return
busy  out  1  high in any state other than ARB_IDLE

Behaviour:
- Reset: state ARB_IDLE. client_gnt=0, gnt_id=0, mem_valid=0, client_done=0, busy=0, rr_ptr=0. Reset mid-transaction aborts with no done pulse.
- FSM states: ARB_IDLE, ARB_REQ, ARB_RSP.
- ARB_IDLE, any client_req bit set:
  - Pick the winner.
  - Next cycle: register client_gnt/gnt_id, set mem_valid=1, go to ARB_REQ.
  - Latency from req to gnt is 1 cycle.
- ARB_REQ: hold mem_valid. When mem_valid&&mem_ready, clear mem_valid next cycle and go to ARB_RSP. The grant is held.
- ARB_RSP, mem_rsp_valid=1:
  - Next cycle: client_done[gnt_id]=1 for one cycle, client_gnt=0, go to ARB_IDLE.
  - In that same cycle the selector evaluates requests again, so back-to-back grants are separated by at most 1 idle cycle.
  - gnt_id keeps its last value.
- mem_rsp_valid seen in ARB_IDLE or ARB_REQ: ignored, no done pulse.
- Winner select, modes 0/1:
  - Scan prio_list0, then 1, then 2.
  - The first listed client with client_req set wins.
  - Duplicate or out-of-range list entries are skipped; if none valid, fall back to lowest requesting index.
  - Prio lists are sampled only in ARB_IDLE; changes during a transaction have no effect.
- Winner select, mode 2:
  - Search ascending from rr_ptr with wrap modulo MEM_ARB_CLIENTS_P.
  - On each grant, rr_ptr <= gnt_idx+1; if gnt_idx==MEM_ARB_CLIENTS_P-1, rr_ptr wraps to 0.
- ctrl.mode is sampled only in ARB_IDLE; a mode change mid-transaction takes effect at the next arbitration.
- A client dropping client_req while granted is ignored; the transaction completes and client_done still pulses.
- client_gnt is always one-hot or zero. mem_valid implies client_gnt!=0.

Decomposition:
- Shared package: arb_states_t enum (ARB_IDLE, ARB_REQ, ARB_RSP) and mode encodings ARB_MODE_STATIC=0, ARB_MODE_DYN=1, ARB_MODE_RR=2, alongside the existing ctrl_reg_t and sorter_states_t.
- One combinational sub-module, prio_pick:
  - Inputs: request vector, ordered candidate list, rr_ptr, mode.
  - Outputs: winner index, found flag.
- FSM and registers stay in client_grant_arb.

Test Plan:
1. Reset released, no req -> all outputs 0, busy=0, for 10 cycles.
2. Mode 0, lists 0/1/2, req=3'b110, mem_ready same cycle as mem_valid, rsp 2 cycles later -> gnt=3'b010 one cycle after req, gnt_id=1, then client_done=3'b010 for one cycle.
3. Mode 1, lists 2/0/1, req=3'b011; lists change to 1/0/2 while in ARB_RSP -> client 0 granted and completes. The next arbitration uses the new lists and grants client 1.
4. Mode 2, req=3'b111 held, three transactions -> grant order 0,1,2, then wraps to 0; rr_ptr 1,2,0,1.
5. mem_ready held low 5 cycles -> mem_valid and gnt stay stable, state ARB_REQ. A spurious mem_rsp_valid in ARB_REQ gives no done pulse.
6. rst asserted during ARB_RSP -> gnt, mem_valid, busy go 0 immediately, no client_done. After release, pending req=3'b001 is granted normally.
